// File: rtl/wh_output_allocator.sv
// Wormhole output-port allocator: round-robin grant locked head-to-tail, with credit-based
// flow control towards the downstream input FIFO.
module wh_output_allocator #(
  parameter int unsigned CREDITS = 4,
  parameter int unsigned CNT_W   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       req,
  input  logic [4:0]       head,
  input  logic [4:0]       tail,
  input  logic             credit_ret,
  output logic [4:0]       gnt,
  output logic [2:0]       sel,
  output logic             fwd_valid,
  output logic [CNT_W-1:0] credit_cnt,
  output logic             busy,
  output logic             credit_err
);

  localparam int unsigned NumPorts = 5;
  localparam logic [CNT_W-1:0] CreditMax = CNT_W'(CREDITS);

  typedef enum logic [0:0] {StIdle, StLocked} allocStateT;

  allocStateT       stateQ, stateD;
  logic [4:0]       gntQ, gntD;
  logic [2:0]       selQ, selD;
  logic             busyQ, busyD;
  logic [2:0]       rrPtrQ, rrPtrD;
  logic [CNT_W-1:0] creditQ, creditD;
  logic             errQ, errD;

  logic [4:0] eligible;
  logic       found;
  logic [2:0] winner;
  logic [3:0] cand;
  logic       hasCredit;
  logic       fwd;
  logic       pktDone;
  logic       grantNow;

  assign eligible  = req & head;
  assign hasCredit = (creditQ != '0);

  // Round-robin search starting just after the last released owner.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 1; k <= NumPorts; k++) begin
      cand = {1'b0, rrPtrQ} + 4'(k);
      if (cand >= 4'(NumPorts)) begin
        cand = cand - 4'(NumPorts);
      end
      if (!found && eligible[cand[2:0]]) begin
        found  = 1'b1;
        winner = cand[2:0];
      end
    end
  end

  assign fwd      = (stateQ == StLocked) && req[selQ] && hasCredit;
  assign pktDone  = fwd && tail[selQ];
  assign grantNow = (stateQ == StIdle) && found && hasCredit;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ  <= StIdle;
      gntQ    <= '0;
      selQ    <= '0;
      busyQ   <= 1'b0;
      rrPtrQ  <= 3'd4;
      creditQ <= CreditMax;
      errQ    <= 1'b0;
    end else begin
      stateQ  <= stateD;
      gntQ    <= gntD;
      selQ    <= selD;
      busyQ   <= busyD;
      rrPtrQ  <= rrPtrD;
      creditQ <= creditD;
      errQ    <= errD;
    end
  end

  // Next-state logic
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:   if (grantNow) stateD = StLocked;
      StLocked: if (pktDone)  stateD = StIdle;
      default:  stateD = StIdle;
    endcase
  end

  // Registered grant bookkeeping; sel is left alone on release so the mux stays steady.
  always_comb begin
    gntD   = gntQ;
    selD   = selQ;
    busyD  = busyQ;
    rrPtrD = rrPtrQ;
    if (grantNow) begin
      gntD  = 5'b00001 << winner;
      selD  = winner;
      busyD = 1'b1;
    end else if (pktDone) begin
      gntD   = '0;
      busyD  = 1'b0;
      rrPtrD = selQ;
    end
  end

  // Credit counter: a forward and a return in the same cycle cancel out.
  always_comb begin
    creditD = creditQ;
    errD    = errQ;
    case ({fwd, credit_ret})
      2'b10: creditD = creditQ - CNT_W'(1);
      2'b01: begin
        if (creditQ == CreditMax) begin
          errD = 1'b1;
        end else begin
          creditD = creditQ + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    gnt        = gntQ;
    sel        = selQ;
    busy       = busyQ;
    fwd_valid  = fwd;
    credit_cnt = creditQ;
    credit_err = errQ;
  end

  assert property (@(posedge clk) disable iff (!reset) $onehot0(gntQ));
  assert property (@(posedge clk) disable iff (!reset) busyQ == (gntQ != '0));
  assert property (@(posedge clk) disable iff (!reset) creditQ <= CreditMax);
  assert property (@(posedge clk) disable iff (!reset)
                   (stateQ == StLocked && !pktDone) |=> $stable(gntQ));

endmodule

// File: tb/tb_wh_output_allocator.sv
// Bench for wh_output_allocator: fixed vector table, directed corner sequences and a
// randomized run, all compared against a packet-level reference model.
module tb_wh_output_allocator;
  localparam int CREDITS = 4;
  localparam int CNT_W   = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       req, head, tail;
  logic             credit_ret;
  logic [4:0]       gnt;
  logic [2:0]       sel;
  logic             fwd_valid;
  logic [CNT_W-1:0] credit_cnt;
  logic             busy;
  logic             credit_err;

  wh_output_allocator #(.CREDITS(CREDITS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .head       (head),
    .tail       (tail),
    .credit_ret (credit_ret),
    .gnt        (gnt),
    .sel        (sel),
    .fwd_valid  (fwd_valid),
    .credit_cnt (credit_cnt),
    .busy       (busy),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  // Reference model: owner index (-1 = nobody), last released owner, credits, sticky error.
  int mOwner, mRr, mCnt, mSel;
  bit mErr;
  // Upstream sources and downstream sink.
  int len[5], pos[5], stall[5];
  int inFlight;
  int retMode;  // 0: no returns, 1: return every slot, 2: random returns
  // Observations of the last cycle.
  logic [4:0] oGnt;
  logic [2:0] oSel, oCnt;
  logic       oFwd, oBusy, oErr;
  bit         expFwd;
  int         fwdOwner;

  typedef struct {
    logic [4:0] r, h, t;
    logic       cr;
    logic [4:0] eg;
    logic [2:0] es;
    logic       ef;
    logic [2:0] ec;
    logic       eb;
  } vecT;
  vecT vt[9];

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nErrors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    mOwner = -1; mRr = 4; mCnt = CREDITS; mErr = 1'b0; mSel = 0;
  endfunction

  function automatic void srcReset();
    for (int i = 0; i < 5; i++) begin
      len[i] = 0; pos[i] = 0; stall[i] = 0;
    end
    inFlight = 0;
  endfunction

  function automatic void modelStep(input logic [4:0] r, h, t, input logic cr, input bit f);
    bit got;
    got = 1'b0;
    if (mOwner < 0) begin
      if (mCnt > 0) begin
        for (int k = 1; k <= 5; k++) begin
          int idx;
          idx = (mRr + k) % 5;
          if (!got && r[idx] && h[idx]) begin
            got = 1'b1; mOwner = idx; mSel = idx;
          end
        end
      end
    end else if (f && t[mOwner]) begin
      mRr = mOwner; mOwner = -1;
    end
    if (f && !cr) mCnt--;
    else if (cr && !f) begin
      if (mCnt == CREDITS) mErr = 1'b1;
      else mCnt++;
    end
  endfunction

  task automatic doCycle(input logic [4:0] r, h, t, input logic cr);
    @(negedge clk);
    req = r; head = h; tail = t; credit_ret = cr;
    #1;
    expFwd = 1'b0;
    if (mOwner >= 0) expFwd = r[mOwner] && (mCnt > 0);
    fwdOwner = mOwner;
    oGnt = gnt; oSel = sel; oFwd = fwd_valid; oCnt = credit_cnt; oBusy = busy; oErr = credit_err;
    chk("gnt", int'(gnt), (mOwner >= 0) ? (1 << mOwner) : 0);
    chk("sel", int'(sel), mSel);
    chk("fwd_valid", int'(fwd_valid), int'(expFwd));
    chk("credit_cnt", int'(credit_cnt), mCnt);
    chk("busy", int'(busy), (mOwner >= 0) ? 1 : 0);
    chk("credit_err", int'(credit_err), int'(mErr));
    @(posedge clk);
    modelStep(r, h, t, cr, expFwd);
  endtask

  task automatic srcCycle(input bit crForce);
    logic [4:0] r, h, t;
    logic       cr;
    int         oldFlight;
    for (int i = 0; i < 5; i++) begin
      r[i] = (len[i] > 0) && (stall[i] == 0);
      h[i] = (pos[i] == 0);
      t[i] = (len[i] > 0) && (pos[i] == len[i] - 1);
    end
    cr = crForce;
    if (retMode == 1 && inFlight > 0) cr = 1'b1;
    if (retMode == 2 && inFlight > 0 && $urandom_range(0, 2) != 0) cr = 1'b1;
    oldFlight = inFlight;
    doCycle(r, h, t, cr);
    if (expFwd) begin
      pos[fwdOwner]++;
      if (pos[fwdOwner] == len[fwdOwner]) begin
        len[fwdOwner] = 0; pos[fwdOwner] = 0;
      end
      inFlight++;
    end
    if (cr && oldFlight > 0) inFlight--;
    for (int i = 0; i < 5; i++) if (stall[i] > 0) stall[i]--;
  endtask

  // Asynchronous reset asserted between edges; the outputs must clear before any clock edge.
  task automatic doReset();
    @(negedge clk);
    req = '0; head = '0; tail = '0; credit_ret = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("reset gnt", int'(gnt), 0);
    chk("reset sel", int'(sel), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset credit_cnt", int'(credit_cnt), CREDITS);
    chk("reset credit_err", int'(credit_err), 0);
    modelReset();
    srcReset();
    retMode = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int order[$];
    int fwdCount;
    bit tailSeen, granted0, grantedAfterTail;

    reset = 1'b1; req = '0; head = '0; tail = '0; credit_ret = 1'b0;
    modelReset(); srcReset(); retMode = 0;

    // Single-flit packet on input 0, then inputs 1 and 3 with three-flit packets.
    vt[0] = '{5'b00001, 5'b00001, 5'b00001, 1'b0, 5'b00000, 3'd0, 1'b0, 3'd4, 1'b0};
    vt[1] = '{5'b00001, 5'b00001, 5'b00001, 1'b0, 5'b00001, 3'd0, 1'b1, 3'd4, 1'b1};
    vt[2] = '{5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0, 3'd3, 1'b0};
    vt[3] = '{5'b01010, 5'b01010, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 3'd3, 1'b0};
    vt[4] = '{5'b01010, 5'b01010, 5'b00000, 1'b1, 5'b00010, 3'd1, 1'b1, 3'd4, 1'b1};
    vt[5] = '{5'b01010, 5'b01000, 5'b00000, 1'b1, 5'b00010, 3'd1, 1'b1, 3'd4, 1'b1};
    vt[6] = '{5'b01010, 5'b01000, 5'b00010, 1'b1, 5'b00010, 3'd1, 1'b1, 3'd4, 1'b1};
    vt[7] = '{5'b01000, 5'b01000, 5'b00000, 1'b0, 5'b00000, 3'd1, 1'b0, 3'd4, 1'b0};
    vt[8] = '{5'b01000, 5'b01000, 5'b00000, 1'b1, 5'b01000, 3'd3, 1'b1, 3'd4, 1'b1};

    doReset();
    for (int i = 0; i < 9; i++) begin
      doCycle(vt[i].r, vt[i].h, vt[i].t, vt[i].cr);
      chk($sformatf("vec%0d gnt", i), int'(oGnt), int'(vt[i].eg));
      chk($sformatf("vec%0d sel", i), int'(oSel), int'(vt[i].es));
      chk($sformatf("vec%0d fwd_valid", i), int'(oFwd), int'(vt[i].ef));
      chk($sformatf("vec%0d credit_cnt", i), int'(oCnt), int'(vt[i].ec));
      chk($sformatf("vec%0d busy", i), int'(oBusy), int'(vt[i].eb));
    end

    // Round robin across five always-requesting single-flit sources.
    doReset();
    for (int c = 0; c < 12; c++) begin
      doCycle(5'b11111, 5'b11111, 5'b11111, (c % 2) == 1);
      if (oFwd) begin
        for (int i = 0; i < 5; i++) if (oGnt[i]) order.push_back(i);
      end
    end
    chk("rr grant count", order.size(), 6);
    for (int j = 0; j < order.size(); j++) chk($sformatf("rr order%0d", j), order[j], j % 5);

    // Credit exhaustion mid-packet, then one returned credit allows exactly one flit.
    doReset();
    len[2] = 6;
    fwdCount = 0;
    for (int c = 0; c < 9; c++) begin
      srcCycle(1'b0);
      if (oFwd) fwdCount++;
    end
    chk("starve fwd count", fwdCount, 4);
    chk("starve fwd_valid", int'(oFwd), 0);
    chk("starve credit_cnt", int'(oCnt), 0);
    chk("starve gnt", int'(oGnt), 5'b00100);
    srcCycle(1'b1);
    fwdCount = 0;
    for (int c = 0; c < 4; c++) begin
      srcCycle(1'b0);
      if (oFwd) fwdCount++;
    end
    chk("one credit one fwd", fwdCount, 1);
    chk("starve gnt held", int'(oGnt), 5'b00100);

    // Owner stalls mid-packet while another input posts a head.
    doReset();
    retMode = 1;
    len[4] = 5;
    for (int c = 0; c < 3; c++) srcCycle(1'b0);
    len[0] = 1;
    stall[4] = 2;
    for (int c = 0; c < 2; c++) begin
      srcCycle(1'b0);
      chk("stall gnt", int'(oGnt), 5'b10000);
      chk("stall fwd_valid", int'(oFwd), 0);
    end
    tailSeen = 1'b0; granted0 = 1'b0; grantedAfterTail = 1'b0;
    for (int c = 0; c < 20 && !granted0; c++) begin
      srcCycle(1'b0);
      if (oGnt == 5'b00001) begin
        granted0 = 1'b1; grantedAfterTail = tailSeen;
      end
      if (oFwd && fwdOwner == 4 && len[4] == 0) tailSeen = 1'b1;
    end
    chk("input0 granted", int'(granted0), 1);
    chk("input0 granted after tail", int'(grantedAfterTail), 1);

    // Credit overflow, simultaneous forward and return, and reset mid-packet.
    doReset();
    srcCycle(1'b1);
    srcCycle(1'b0);
    chk("overflow credit_cnt", int'(oCnt), CREDITS);
    chk("overflow credit_err", int'(oErr), 1);
    len[1] = 6;
    for (int c = 0; c < 3; c++) srcCycle(1'b0);
    srcCycle(1'b1);
    chk("fwd+ret fwd_valid", int'(oFwd), 1);
    chk("fwd+ret credit_cnt before", int'(oCnt), 2);
    srcCycle(1'b0);
    chk("fwd+ret credit_cnt after", int'(oCnt), 2);
    chk("midpacket busy", int'(oBusy), 1);
    doReset();

    // Randomized traffic against the model.
    doReset();
    retMode = 2;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (len[i] == 0 && $urandom_range(0, 3) == 0) len[i] = $urandom_range(1, 5);
        if (stall[i] == 0 && $urandom_range(0, 7) == 0) stall[i] = $urandom_range(1, 2);
      end
      srcCycle(1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/wh_output_allocator.md
Name: wh_output_allocator

Overview:
- Wormhole output-port allocator for one router output (East/North/West/South/Local, indices 0-4).
- Shares the output port among the five input controllers with round-robin priority.
- Locks the grant to one input from the head flit through the tail flit.
- Tracks downstream buffer space with credits instead of a `full` flag, and drives the output-mux select and a per-cycle forward strobe.

Parameters:
- CREDITS, 4, depth of the downstream input FIFO; the reset value and ceiling of the credit counter.
- CNT_W, 3, credit counter width; must satisfy 2^CNT_W > CREDITS.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- req  input  5  per-input request; bit i = input i holds a flit routed to this output.
- head  input  5  bit i = the flit at input i is a head flit (qualified by req[i]).
- tail  input  5  bit i = the flit at input i is a tail flit; head&tail together = single-flit packet.
- credit_ret  input  1  one-cycle pulse from downstream: one buffer slot freed.
- gnt  output  5  registered one-hot grant to the owning input; 0 when idle.
- sel  output  3  registered binary index of the owner (0-4), feeds the output mux.
- fwd_valid  output  1  combinational; a flit from the owner is transferred this cycle, and the owner pops its FIFO.
- credit_cnt  output  CNT_W  current available downstream credits.
- busy  output  1  registered; 1 while in LOCKED.
- credit_err  output  1  sticky; set on a credit return while credit_cnt==CREDITS.

Behaviour:
- Reset (asynchronous, active-low) forces:
  - state=IDLE, gnt=0, sel=0, busy=0;
  - rr_ptr=4, so port 0 has highest priority after reset;
  - credit_cnt=CREDITS, credit_err=0.
- States are IDLE and LOCKED.
- IDLE behaviour:
  - A request is eligible at input i when req[i]&head[i].
  - If any input is eligible and credit_cnt>0, pick the first eligible index searching rr_ptr+1, rr_ptr+2, ... modulo 5.
  - On the next clk edge: gnt=onehot(winner), sel=winner, owner=winner, busy=1, state=LOCKED.
  - Non-head requests are ignored. With credit_cnt==0, stay in IDLE with gnt=0.
- LOCKED behaviour:
  - fwd_valid = req[owner] & (credit_cnt!=0). It is 0 in IDLE.
  - If the owner deasserts req mid-packet, the allocator stalls and stays locked. Other inputs are never granted, even if they request.
  - When fwd_valid & tail[owner]: on that edge go to IDLE, gnt=0, busy=0, rr_ptr=owner. sel holds its last value.
- Latency:
  - An eligible request at edge N with credits is granted from edge N (gnt visible in cycle N+1).
  - First forward is possible in cycle N+1.
  - The next packet's grant comes one cycle after its tail forward, leaving one idle bubble per packet.
- Credit arithmetic, applied every cycle:
  - fwd_valid only: credit_cnt-1.
  - credit_ret only: credit_cnt+1.
  - Both: unchanged.
- Credit boundary cases:
  - credit_cnt never underflows, because fwd_valid is gated by credit_cnt!=0.
  - credit_ret while credit_cnt==CREDITS with no simultaneous fwd: counter saturates and credit_err sets. credit_err clears only on reset.
- Arbitration rules:
  - Round-robin pointer updates only on packet release.
  - Priority is fair across packets and never preempts within a packet.
- Reset mid-packet returns to IDLE immediately and drops the grant. Upstream/downstream recovery belongs to the system.

Test Plan:
- Reset, then req=5'b00001, head=tail=5'b00001 → gnt=5'b00001 and sel=0 next cycle. fwd_valid=1 for one cycle, then gnt=0 and credit_cnt=3.
- Inputs 1 and 3 both post 3-flit packets (head on flit 1, tail on flit 3), credit_ret pulsed every cycle → input 1 granted first and gets three consecutive fwd_valid with sel=1. After one idle cycle input 3 gets gnt=5'b01000, sel=3.
- Continuous heads on all five inputs, single-flit packets, credits replenished → grant order 0,1,2,3,4,0 with no repeats.
- CREDITS=4, no credit_ret, input 2 sends a 6-flit packet → four forwards, then fwd_valid=0 and credit_cnt=0 while gnt stays 5'b00100. A single credit_ret pulse → exactly one more forward.
- Locked on input 4, input 0 asserts a head mid-packet and input 4 drops req for 2 cycles → gnt unchanged, fwd_valid=0 for those cycles, no grant to input 0 until input 4's tail is forwarded.
- credit_ret pulsed at credit_cnt=4 with no forward → credit_cnt stays 4 and credit_err=1. Simultaneous fwd_valid and credit_ret at credit_cnt=2 → stays 2. Assert reset mid-packet → gnt=0, busy=0, credit_cnt=4, credit_err=0 asynchronously.
